nic_resp: RTL and testbench

- Memory-mapped network interface controller. It is the responder on the CPU core's data-memory port: the core drives addr/d_in/nicEn/nicWrEn and reads d_out.
- Holds a one-entry input buffer fed by the ring router and a one-entry output buffer drained to the router.
- Each buffer has a status register that CPU software polls through four register addresses.
- Sits between one CPU core and its local ring router port.

---
 rtl/nic_resp.sv | 124 ++++++++++++
 tb/tb_nic_resp.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_resp.sv
// nic_resp: memory-mapped network interface controller.
//
// Responder on a CPU core's data-memory port, bridging the core to its local
// ring router port through a one-entry input buffer (router -> CPU) and a
// one-entry output buffer (CPU -> router). Software polls a status register
// per buffer and moves packets with plain loads and stores.
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   addr          register select: 00 in_buf, 01 in_status, 10 out_buf, 11 out_status
//   d_in          CPU write data
//   d_out         CPU read data, registered (valid the cycle after the request)
//   nicEn         access strobe
//   nicWrEn       1 = write, 0 = read (qualified by nicEn)
//   net_so        send strobe to router
//   net_ro        router ready to accept a packet
//   net_do        packet to router (zero while the output buffer is empty)
//   net_polarity  router's current virtual-channel polarity
//   net_si        router send strobe into the NIC
//   net_ri        NIC ready to accept a packet
//   net_di        packet from router
//
// All data buses are indexed [0:DW-1]; VC_BIT selects the virtual-channel bit.
module nic_resp #(
  parameter int DW     = 64,
  parameter int VC_BIT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    addr,
  input  logic [0:DW-1] d_in,
  output logic [0:DW-1] d_out,
  input  logic          nicEn,
  input  logic          nicWrEn,
  output logic          net_so,
  input  logic          net_ro,
  output logic [0:DW-1] net_do,
  input  logic          net_polarity,
  input  logic          net_si,
  output logic          net_ri,
  input  logic [0:DW-1] net_di
);

  localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

  logic [0:DW-1] in_buf;
  logic [0:DW-1] out_buf;
  logic          in_full;
  logic          out_full;

  logic rd_req;
  logic wr_req;
  logic arrive;
  logic take;
  logic send_ok;
  logic post;

  assign rd_req = nicEn & ~nicWrEn;
  assign wr_req = nicEn & nicWrEn;

  // The router may only send on the channel whose polarity differs from the
  // packet's VC bit, so a packet can sit ready while the ring is in the
  // wrong phase.
  assign send_ok = out_full & net_ro & (out_buf[VC_BIT] != net_polarity);

  // Arrival needs an empty buffer and consumption needs a full one, so these
  // two can never fire on the same edge.
  assign arrive = net_si & ~in_full;
  assign take   = rd_req & (addr == ADDR_IN_BUF) & in_full;

  // A write landing on the same edge as a send completes is dropped because
  // out_full is still set at that edge; software must re-poll.
  assign post = wr_req & (addr == ADDR_OUT_BUF) & ~out_full;

  assign net_ri = ~in_full;
  assign net_so = send_ok;
  assign net_do = out_full ? out_buf : '0;

  // Input buffer: filled by the router, emptied by a CPU read of in_buf.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else if (arrive) begin
      in_buf  <= net_di;
      in_full <= 1'b1;
    end else if (take) begin
      in_full <= 1'b0;
    end
  end

  // Output buffer: filled by a CPU write, emptied by a completed send.
  // out_buf keeps its contents after a send so it can still be read back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else if (send_ok) begin
      out_full <= 1'b0;
    end else if (post) begin
      out_buf  <= d_in;
      out_full <= 1'b1;
    end
  end

  // Registered read data; status flags sit in the least significant bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out <= '0;
    end else if (rd_req) begin
      case (addr)
        ADDR_IN_BUF:     d_out <= in_buf;
        ADDR_IN_STATUS:  d_out <= {{(DW-1){1'b0}}, in_full};
        ADDR_OUT_BUF:    d_out <= out_buf;
        ADDR_OUT_STATUS: d_out <= {{(DW-1){1'b0}}, out_full};
        default:         d_out <= d_out;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_resp.sv
// tb_nic_resp: self-checking bench for nic_resp.
//
// Directed steps walk through reset, packet receive, packet send, dropped
// writes, ignored router strobes and asynchronous reset; a randomized phase
// then exercises arbitrary interleavings. A behavioural model of the two
// mailboxes predicts every output after each clock edge.
module tb_nic_resp;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;

  int errors = 0;
  int checks = 0;

  // Model state: one mailbox per direction plus the last CPU read value.
  // The VC bit is the packet's most significant bit (index 0 of [0:63]).
  logic [63:0] m_in_pkt;
  bit          m_in_valid;
  logic [63:0] m_out_pkt;
  bit          m_out_valid;
  logic [63:0] m_rdata;

  nic_resp #(.DW(64), .VC_BIT(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_send();
    return m_out_valid && net_ro && (m_out_pkt[63] != net_polarity);
  endfunction

  task automatic model_clear();
    m_in_pkt    = '0;
    m_in_valid  = 0;
    m_out_pkt   = '0;
    m_out_valid = 0;
    m_rdata     = '0;
  endtask

  // Advance the model across one clock edge using the inputs present there.
  task automatic model_edge();
    bit reading;
    bit writing;
    bit sending;
    reading = nicEn && !nicWrEn;
    writing = nicEn && nicWrEn;
    sending = model_send();
    if (reading) begin
      if (addr == 2'd0) m_rdata = m_in_pkt;
      else if (addr == 2'd1) m_rdata = {63'd0, m_in_valid};
      else if (addr == 2'd2) m_rdata = m_out_pkt;
      else m_rdata = {63'd0, m_out_valid};
    end
    if (!m_in_valid && net_si) begin
      m_in_pkt   = net_di;
      m_in_valid = 1;
    end else if (reading && addr == 2'd0) begin
      m_in_valid = 0;
    end
    if (sending) begin
      m_out_valid = 0;
    end else if (writing && addr == 2'd2 && !m_out_valid) begin
      m_out_pkt   = d_in;
      m_out_valid = 1;
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, ".d_out"}, d_out, m_rdata);
    check_val({tag, ".net_ri"}, {63'd0, net_ri}, {63'd0, !m_in_valid});
    check_val({tag, ".net_so"}, {63'd0, net_so}, {63'd0, model_send()});
    check_val({tag, ".net_do"}, net_do, m_out_valid ? m_out_pkt : 64'd0);
  endtask

  // One clock: inputs already driven, update the model, sample 1ns later.
  task automatic apply_stimulus(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  task automatic idle();
    nicEn   = 0;
    nicWrEn = 0;
    net_si  = 0;
  endtask

  task automatic cpu_read(input logic [1:0] a, input string tag);
    nicEn = 1; nicWrEn = 0; addr = a;
    apply_stimulus(tag);
    idle();
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [63:0] v, input string tag);
    nicEn = 1; nicWrEn = 1; addr = a; d_in = v;
    apply_stimulus(tag);
    idle();
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1;
    #1;
    model_clear();
    check_output({tag, ".async"});
    @(posedge clk);
    #1;
    reset = 0;
    check_output({tag, ".held"});
  endtask

  initial begin
    logic [63:0] pkt_a;
    logic [63:0] pkt_b;
    pkt_a = 64'hDEAD_BEEF_0123_4567;
    pkt_b = 64'h0BAD_F00D_AAAA_5555;

    // Reset for three cycles with the router ready.
    reset = 1; addr = 0; d_in = 0; nicEn = 0; nicWrEn = 0;
    net_ro = 1; net_polarity = 0; net_si = 0; net_di = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    check_val("rst.d_out", d_out, 64'd0);
    check_val("rst.net_so", {63'd0, net_so}, 64'd0);
    check_val("rst.net_ri", {63'd0, net_ri}, 64'd1);
    check_val("rst.net_do", net_do, 64'd0);
    cpu_read(2'd1, "rst.rd01");
    check_val("rst.in_status", d_out, 64'd0);
    cpu_read(2'd3, "rst.rd11");
    check_val("rst.out_status", d_out, 64'd0);

    // Receive one packet from the router and consume it.
    net_si = 1; net_di = pkt_a;
    apply_stimulus("rx.arrive");
    idle();
    check_val("rx.net_ri_low", {63'd0, net_ri}, 64'd0);
    cpu_read(2'd1, "rx.rd01");
    check_val("rx.in_status_full", d_out, 64'd1);
    cpu_read(2'd0, "rx.rd00");
    check_val("rx.in_buf", d_out, pkt_a);
    check_val("rx.net_ri_back", {63'd0, net_ri}, 64'd1);
    cpu_read(2'd1, "rx.rd01b");
    check_val("rx.in_status_empty", d_out, 64'd0);

    // Send a VC=1 packet; it waits until the polarity differs.
    net_ro = 1; net_polarity = 1;
    cpu_write(2'd2, 64'h8000_0000_0000_0042, "tx.write");
    check_val("tx.blocked", {63'd0, net_so}, 64'd0);
    cpu_read(2'd3, "tx.rd11");
    check_val("tx.out_status_full", d_out, 64'd1);
    net_polarity = 0;
    #1;
    check_val("tx.net_so", {63'd0, net_so}, 64'd1);
    check_val("tx.net_do", net_do, 64'h8000_0000_0000_0042);
    apply_stimulus("tx.sent");
    check_val("tx.one_cycle", {63'd0, net_so}, 64'd0);
    cpu_read(2'd3, "tx.rd11b");
    check_val("tx.out_status_empty", d_out, 64'd0);

    // A write to a full output buffer is dropped.
    net_ro = 0;
    cpu_write(2'd2, 64'h8000_0000_0000_0055, "drop.first");
    cpu_write(2'd2, 64'h0000_0000_0000_1234, "drop.second");
    cpu_read(2'd2, "drop.rd10");
    check_val("drop.out_buf", d_out, 64'h8000_0000_0000_0055);
    net_ro = 1;
    #1;
    check_val("drop.net_do", net_do, 64'h8000_0000_0000_0055);
    check_val("drop.net_so", {63'd0, net_so}, 64'd1);
    apply_stimulus("drop.sent");

    // Router strobes into a full input buffer and writes to 00/01/11 are ignored.
    net_si = 1; net_di = pkt_a;
    apply_stimulus("ign.fill");
    net_di = pkt_b;
    apply_stimulus("ign.extra_si");
    idle();
    cpu_write(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, "ign.wr00");
    cpu_write(2'd1, 64'h0, "ign.wr01");
    cpu_write(2'd3, 64'h0, "ign.wr11");
    cpu_read(2'd0, "ign.rd00");
    check_val("ign.in_buf", d_out, pkt_a);

    // Fill both buffers, then reset in the middle of a cycle.
    net_si = 1; net_di = pkt_b;
    apply_stimulus("ar.fill_in");
    idle();
    net_ro = 0;
    cpu_write(2'd2, 64'h4000_0000_0000_0077, "ar.fill_out");
    cpu_read(2'd2, "ar.rd10");
    #2;
    reset = 1;
    #1;
    check_val("ar.net_ri", {63'd0, net_ri}, 64'd1);
    check_val("ar.net_so", {63'd0, net_so}, 64'd0);
    check_val("ar.d_out", d_out, 64'd0);
    check_val("ar.net_do", net_do, 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 0;
    net_ro = 1;
    cpu_read(2'd1, "ar.rd01");
    check_val("ar.in_status", d_out, 64'd0);
    cpu_read(2'd3, "ar.rd11");
    check_val("ar.out_status", d_out, 64'd0);

    // Randomized interleavings checked against the model every cycle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse("rnd.reset");
      end else begin
        nicEn        = ($urandom_range(0, 2) != 0);
        nicWrEn      = $urandom_range(0, 1);
        addr         = 2'($urandom_range(0, 3));
        d_in         = {$urandom, $urandom};
        net_ro       = ($urandom_range(0, 3) != 0);
        net_polarity = $urandom_range(0, 1);
        net_si       = ($urandom_range(0, 2) == 0);
        net_di       = {$urandom, $urandom};
        apply_stimulus("rnd");
      end
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
